apb_slave_mem: RTL and testbench

//  APB completer sitting directly downstream of APB_Protocol's master; terminates its setup/access transfers.

---
 rtl/apb_slave_mem_pkg.sv | 26 ++
 rtl/apb_slave_mem_if.sv | 27 ++
 rtl/apb_slave_mem_array.sv | 38 +++
 rtl/apb_slave_mem.sv | 140 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the apb_slave_mem completer.
package apb_slave_mem_pkg;

    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_slv_state_t;

    typedef logic [1:0] apb_err_t;

    localparam apb_err_t ERR_NONE      = 2'd0;
    localparam apb_err_t ERR_RANGE     = 2'd1;
    localparam apb_err_t ERR_UNWRITTEN = 2'd2;

    // Classify a completing transfer; range errors take priority over unwritten reads.
    function automatic apb_err_t err_code(input logic in_range, input logic is_write,
                                          input logic written);
        if (!in_range) return ERR_RANGE;
        if (!is_write && !written) return ERR_UNWRITTEN;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the upstream master and the apb_slave_mem completer.
interface apb_slave_mem_if
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) ();

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_mem_array.sv
// DEPTH x 32 storage with per-entry written flags: one write port, one async read port.
module apb_slave_mem_array
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    output logic [APB_DATA_W-1:0] rdata_c_o,
    output logic                  written_c_o
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      written_q;

    // Contents are deliberately not reset; only the flags are.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            written_q <= '0;
        end else if (we_i) begin
            written_q[idx_i] <= 1'b1;
        end
    end

    assign rdata_c_o   = mem_q[idx_i];
    assign written_c_o = written_q[idx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with DEPTH x 32 register memory, range and unwritten-read errors.
// Optional wait states enabled by defining APB_SLV_WAIT_EN.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_slave_mem_if.slave  bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 2);
`ifdef APB_SLV_WAIT_EN
    localparam int unsigned WAIT_N = WAIT_CYCLES;
`else
    localparam int unsigned WAIT_N = 0;
`endif

    apb_slv_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  write_q, write_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [ADDR_W-1:0]     op_addr_c;
    logic                  op_write_c;
    logic [APB_DATA_W-1:0] op_wdata_c;
    logic                  op_en_c;
    logic                  in_range_c;
    apb_err_t              err_c;
    logic                  mem_we_c;
    logic [APB_DATA_W-1:0] mem_rdata_c;
    logic                  mem_written_c;

    // A zero-wait op completes on the setup edge, so the operand comes straight off the bus.
    assign op_addr_c  = (state_q == IDLE) ? bus.PADDR  : addr_q;
    assign op_write_c = (state_q == IDLE) ? bus.PWRITE : write_q;
    assign op_wdata_c = (state_q == IDLE) ? bus.PWDATA : wdata_q;
    assign in_range_c = op_addr_c < ADDR_W'(DEPTH);
    assign err_c      = err_code(in_range_c, op_write_c, mem_written_c);
    assign mem_we_c   = op_en_c && op_write_c && in_range_c && !PRESET;

    apb_slave_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i       (PCLK),
        .rst_i       (PRESET),
        .we_i        (mem_we_c),
        .idx_i       (op_addr_c[IDX_W-1:0]),
        .wdata_i     (op_wdata_c),
        .rdata_c_o   (mem_rdata_c),
        .written_c_o (mem_written_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = pslverr_q;
        op_en_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    addr_d  = bus.PADDR;
                    write_d = bus.PWRITE;
                    wdata_d = bus.PWDATA;
                    if (WAIT_N == 0) begin
                        op_en_c = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_N - 1);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!(bus.PSEL && bus.PENABLE)) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    op_en_c = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (op_en_c) begin
            pready_d  = 1'b1;
            pslverr_d = (err_c != ERR_NONE);
            prdata_d  = (!op_write_c && err_c == ERR_NONE) ? mem_rdata_c : '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem with a model-fed expectation queue.
module tb_apb_slave_mem;
    import apb_slave_mem_pkg::*;

    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned DEPTH       = 64;
    localparam int unsigned WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int unsigned WAIT_N = WAIT_CYCLES;
`else
    localparam int unsigned WAIT_N = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_slave_mem_if #(.ADDR_W(ADDR_W)) bus ();

    apb_slave_mem #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem[DEPTH];
    bit          mdl_wr[DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_wr[i] = 1'b0;
    endtask

    // Expected outcome computed from the reference model at issue time.
    task automatic push_exp(input bit wr, input int addr, input logic [31:0] data);
        exp_t e;
        e.err = 1'b0; e.data = '0; e.chk_data = !wr;
        if (addr >= int'(DEPTH)) begin
            e.err = 1'b1; e.chk_data = 1'b1;
        end else if (wr) begin
            mdl_mem[addr] = data;
            mdl_wr[addr]  = 1'b1;
        end else if (!mdl_wr[addr]) begin
            e.err = 1'b1;
        end else begin
            e.data = mdl_mem[addr];
        end
        sb.push_back(e);
    endtask

    task automatic xfer(input bit wr, input int addr, input logic [31:0] data, input string tag);
        int   cyc;
        exp_t e;
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = ADDR_W'(addr); bus.PWDATA = data;
        push_exp(wr, addr, data);
        @(negedge clk);
        bus.PENABLE = 1'b1;
        cyc = 1;
        while (bus.PREADY !== 1'b1 && cyc <= int'(WAIT_N) + 8) begin
            @(negedge clk);
            bus.PADDR  = ~bus.PADDR;
            bus.PWDATA = ~bus.PWDATA;
            cyc++;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 32'(cyc), 32'(WAIT_N + 1));
        check({tag, " pslverr"}, 32'(bus.PSLVERR), 32'(e.err));
        if (e.chk_data) check({tag, " prdata"}, bus.PRDATA, e.data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rnd;
        rst = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset pready", 32'(bus.PREADY), 32'd0);
        check("reset pslverr", 32'(bus.PSLVERR), 32'd0);
        check("reset prdata", bus.PRDATA, 32'd0);
        rst = 1'b0;

        xfer(1'b0, 5, '0, "rd5 after reset");
        xfer(1'b1, 10, 32'h23, "wr10");
        xfer(1'b0, 10, '0, "rd10");
        idle(2);
        check("hold prdata", bus.PRDATA, 32'h23);
        check("idle pready", 32'(bus.PREADY), 32'd0);

        xfer(1'b1, 70, 32'hDEAD, "wr70 range");
        xfer(1'b0, 70, '0, "rd70 range");
        xfer(1'b0, 6, '0, "rd6 alias");
        xfer(1'b0, 10, '0, "rd10 intact");

        xfer(1'b0, 45, '0, "rd45 unwritten");
        xfer(1'b1, 45, 32'd9, "wr45");
        xfer(1'b0, 45, '0, "rd45");

        xfer(1'b1, 3, 32'h11, "wr3 first");
        xfer(1'b1, 3, 32'hAB, "wr3 last");
        xfer(1'b0, 3, '0, "rd3 last wins");
        xfer(1'b0, 63, '0, "rd63 unwritten");
        xfer(1'b1, 63, 32'hFFFF_FFFF, "wr63 top");
        xfer(1'b0, 63, '0, "rd63 top");
        xfer(1'b1, 64, 32'h1, "wr64 range");
        idle(1);

        for (int i = 0; i < 32; i++) begin
            rnd = $urandom;
            xfer(1'b1, i, rnd, "sweep wr");
        end
        for (int i = 0; i < 32; i++) xfer(1'b0, i, '0, "sweep rd");
        idle(1);

`ifdef APB_SLV_WAIT_EN
        // Master drops PSEL while the slave is still inserting wait states.
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = ADDR_W'(7); bus.PWDATA = 32'h55;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        check("abort wait pready", 32'(bus.PREADY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
            check("abort pready", 32'(bus.PREADY), 32'd0);
        end
        xfer(1'b0, 7, '0, "rd7 after abort");
        idle(1);
`endif

        // Reset lands on the edge that would otherwise commit the write.
        xfer(1'b0, 4, '0, "rd4 before reset");
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = ADDR_W'(7); bus.PWDATA = 32'h66;
`ifdef APB_SLV_WAIT_EN
        @(negedge clk);
        bus.PENABLE = 1'b1;
`endif
        rst = 1'b1;
        @(negedge clk);
        check("midreset pready", 32'(bus.PREADY), 32'd0);
        check("midreset pslverr", 32'(bus.PSLVERR), 32'd0);
        check("midreset prdata", bus.PRDATA, 32'd0);
        rst = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        model_reset();
        idle(1);
        xfer(1'b0, 7, '0, "rd7 after reset");
        xfer(1'b0, 4, '0, "rd4 flags cleared");
        xfer(1'b1, 7, 32'h77, "wr7 post reset");
        xfer(1'b0, 7, '0, "rd7 post reset");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
